// File: rtl/cpu_pkg.sv
// Shared types and constants for the decode-stage scoreboard and forwarding logic.
package cpu_pkg;

    // Wide enough for a ready-stage field of any pipeline up to 16 tracked stages
    localparam int READY_MAX_W = 4;

    localparam logic [READY_MAX_W-1:0] READY_EX  = 4'd0;
    localparam logic [READY_MAX_W-1:0] READY_MEM = 4'd1;
    localparam logic [READY_MAX_W-1:0] READY_WB  = 4'd2;

    localparam logic [READY_MAX_W:0] FWD_FROM_RF = '1;

    typedef struct packed {
        logic                   valid;
        logic [4:0]             idx;
        logic [READY_MAX_W-1:0] ready;
    } sb_entry_t;

endpackage

// File: rtl/scoreboard_src_lookup.sv
// Priority search of the scoreboard for one source operand: youngest matching
// producer decides between forwarding from its stage or stalling.
module scoreboard_src_lookup
    import cpu_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int RS_W  = $clog2(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0] entries,
    input  logic [4:0]            src_idx,
    input  logic                  src_used,
    output logic                  hit,
    output logic [RS_W:0]         stage,
    output logic                  must_stall
);

    // Walk oldest to youngest so the youngest match overwrites any older one
    always_comb begin
        hit        = 1'b0;
        stage      = FWD_FROM_RF[RS_W:0];
        must_stall = 1'b0;
        if (src_used && src_idx != 5'd0) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (entries[k].valid && entries[k].idx == src_idx) begin
                    if (READY_MAX_W'(k) >= entries[k].ready) begin
                        hit        = 1'b1;
                        stage      = (RS_W + 1)'(k);
                        must_stall = 1'b0;
                    end else begin
                        hit        = 1'b0;
                        stage      = FWD_FROM_RF[RS_W:0];
                        must_stall = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/scoreboard_fwd_unit.sv
// Decode-stage hazard unit: shift-register scoreboard of in-flight destinations,
// per-source operand forwarding, load-use/multi-cycle stall and a stall counter.
module scoreboard_fwd_unit
    import cpu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int RS_W    = $clog2(DEPTH),
    parameter int CNT_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_issue,
    input  logic                       id_flush,
    input  logic                       pipe_hold,
    input  logic                       id_reg_wr,
    input  logic [4:0]                 id_dest_idx,
    input  logic [RS_W-1:0]            id_ready_stage,
    input  logic [NUM_SRC*5-1:0]       src_idx,
    input  logic [NUM_SRC-1:0]         src_used,
    input  logic [NUM_SRC*XLEN-1:0]    rf_data,
    input  logic [DEPTH*XLEN-1:0]      stage_data,
    input  logic                       wb_wr_en,
    input  logic [4:0]                 wb_wr_idx,
    input  logic [XLEN-1:0]            wb_wr_data,
    output logic [NUM_SRC*XLEN-1:0]    src_value,
    output logic [NUM_SRC*(RS_W+1)-1:0] src_fwd_stage,
    output logic                       stall,
    output logic [CNT_W-1:0]           stall_count
);

    sb_entry_t [DEPTH-1:0] entries;
    sb_entry_t             new_entry;
    logic [NUM_SRC-1:0]    src_stall;
    logic [XLEN-1:0]       stage_arr [DEPTH];

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            stage_arr[k] = stage_data[k*XLEN +: XLEN];
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic            hit;
        logic [RS_W:0]   stage;
        logic [4:0]      idx;
        logic [XLEN-1:0] rf;
        logic [XLEN-1:0] value;

        assign idx = src_idx[s*5 +: 5];
        assign rf  = rf_data[s*XLEN +: XLEN];

        scoreboard_src_lookup #(
            .DEPTH (DEPTH),
            .RS_W  (RS_W)
        ) u_lookup (
            .entries    (entries),
            .src_idx    (idx),
            .src_used   (src_used[s]),
            .hit        (hit),
            .stage      (stage),
            .must_stall (src_stall[s])
        );

        // x0 is hard-wired zero; a same-cycle regfile write is bypassed when nothing younger is in flight
        always_comb begin
            if (idx == 5'd0) begin
                value = '0;
            end else if (hit) begin
                value = stage_arr[stage[RS_W-1:0]];
            end else if (src_used[s] && !src_stall[s] && wb_wr_en && wb_wr_idx == idx) begin
                value = wb_wr_data;
            end else begin
                value = rf;
            end
        end

        assign src_value[s*XLEN +: XLEN]         = value;
        assign src_fwd_stage[s*(RS_W+1) +: RS_W+1] = stage;
    end

    assign stall = id_issue & ~id_flush & (|src_stall);

    // A stalled, flushed or non-writing instruction enters the pipe as a bubble
    always_comb begin
        new_entry.valid = id_issue & ~stall & ~id_flush & id_reg_wr & (id_dest_idx != 5'd0);
        new_entry.idx   = id_dest_idx;
        new_entry.ready = READY_MAX_W'(id_ready_stage);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                entries[k] <= '{valid: 1'b0, idx: 5'd0, ready: READY_EX};
            end
            stall_count <= '0;
        end else if (!pipe_hold) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                entries[k] <= entries[k-1];
            end
            entries[0] <= new_entry;
            if (stall && stall_count != '1) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/scoreboard_fwd_unit.md
Name: scoreboard_fwd_unit

Overview:
Parametrised successor to the decode-stage hazard/forwarding logic. It keeps its own shift-register scoreboard of in-flight destination registers for DEPTH post-decode stages, with a per-instruction result-ready stage. From that it generates per-source forwarding muxes, load-use/multi-cycle stalls and a stall counter. It sits in ID between the register file read ports and the ID/EX register and replaces per-stage comparator wiring.

Parameters:
XLEN, 32, datapath width
NUM_SRC, 2, number of source operands per instruction
DEPTH, 3, tracked post-ID stages (0=ID/EX … DEPTH-1=MEM/WB)
RS_W, $clog2(DEPTH), width of ready-stage field
CNT_W, 32, stall counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
id_issue  in  1  ID holds a valid instruction this cycle
id_flush  in  1  squash ID instruction (branch taken); forces bubble into stage 0
pipe_hold  in  1  downstream freeze; scoreboard does not advance
id_reg_wr  in  1  ID instruction writes rd
id_dest_idx  in  5  rd of ID instruction
id_ready_stage  in  RS_W  first stage whose data port carries the result (ALU 0, load 2)
src_idx  in  NUM_SRC*5  source register indices
src_used  in  NUM_SRC  source actually read by the instruction
rf_data  in  NUM_SRC*XLEN  register-file read data
stage_data  in  DEPTH*XLEN  result visible at stage k (stage 0 combinational EX output)
wb_wr_en  in  1  regfile write this cycle
wb_wr_idx  in  5  regfile write index
wb_wr_data  in  XLEN  regfile write data
src_value  out  NUM_SRC*XLEN  resolved operand values
src_fwd_stage  out  NUM_SRC*(RS_W+1)  debug: stage forwarded from; all-ones = regfile/WB
stall  out  1  hold IF/ID, insert bubble
stall_count  out  CNT_W  cycles with stall=1, saturating

Behaviour:
- Entry k = {valid, idx[4:0], ready[RS_W-1:0]}. Reset clears all valid bits and stall_count. Outputs are combinational from these and from the inputs, so stall=0 after reset.
- Advance (pipe_hold=0), at posedge:
  - entry[k+1] <= entry[k];
  - entry[0] <= {id_issue & ~stall & ~id_flush & id_reg_wr & (id_dest_idx!=0), id_dest_idx, id_ready_stage};
  - entry[DEPTH-1] is discarded.
- pipe_hold=1: all entries frozen. Stall logic is still evaluated, but stall_count does not increment.
- Per source s with src_used[s]=1 and src_idx[s]!=0:
  - Search k=0..DEPTH-1; the youngest matching valid entry wins.
  - Match with k>=ready: src_value=stage_data[k], fwd_stage=k.
  - Match with k<ready: stall contribution=1. src_value is don't-care but driven with rf_data.
  - No match: if wb_wr_en & wb_wr_idx==src_idx[s]!=0, use wb_wr_data; else use rf_data. fwd_stage all-ones.
- Sources with src_used=0 or index x0 never stall. Their src_value is rf_data, except x0, which is forced to 0.
- stall = OR over sources of the stall contribution, gated by id_issue & ~id_flush.
- While stalled, entry[0] receives a bubble, so the producer moves one stage per cycle until k>=ready.
- Load-use with the ALU consumer directly behind the load (ready=2) gives 2 stall cycles at DEPTH=3 (k=0,1), then forwards from stage 2.
- The youngest match wins even if an older entry is ready, so a WAW pair never returns stale data.
- stall_count: +1 per cycle with stall=1 & pipe_hold=0, saturating at all-ones.
- Reset asserted mid-operation clears the scoreboard immediately (asynchronous). In-flight producers are forgotten; the pipeline is expected to be flushed with it.

Decomposition:
- Shared package (cpu_pkg) holds:
  - sb_entry_t struct;
  - READY_EX=0, READY_MEM=1, READY_WB=2 constants;
  - FWD_FROM_RF encoding.
- Sub-module scoreboard_src_lookup, one per source via generate. It is the combinational priority search returning {hit, stage, must_stall}.
- The top level holds the entry shift register, the stall OR and the counter.

Test Plan:
- Producer `add x5` (ready 0) issued, next cycle consumer reads x5 → stall=0, src_value=stage_data[0], fwd_stage=0.
- `lw x6` (ready 2), consumer of x6 next → stall=1 for 2 cycles, stall_count=2, then src_value=stage_data[2]=0xDEADBEEF.
- Two writes to x7 (entries at k=0 ready 0 with value 0x11, k=1 with value 0x22), consumer reads x7 → 0x11.
- Consumer reads x0 while an entry with idx 0 is present and rf_data=0x55 → src_value=0, no stall; an issue with rd=x0 sets valid=0.
- wb_wr_en=1, idx=9, data=0xABCD, no scoreboard hit, rf_data stale 0x0 → src_value=0xABCD.
- pipe_hold=1 during a load-use stall for 3 cycles → entries frozen, stall held, stall_count unchanged. rst low mid-stall → stall=0 and counter=0 immediately.
